exu_upimm_pipe: RTL and testbench



---
 rtl/exu_pkg.sv | 24 ++
 rtl/exu_pipe_slice.sv | 55 +++++
 rtl/exu_upimm_pipe.sv | 133 +++++++++++++
 tb/tb_exu_upimm_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// exu_pkg: shared definitions for the U-type (LUI/AUIPC) execution path.
//   OPCODE_LUI / OPCODE_AUIPC : major opcodes handled by exu_upimm_pipe
//   upimm_payload_t           : per-stage payload at the default widths
//   is_upimm()                : true for the two opcodes this unit executes
package exu_pkg;

    localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;

    localparam int XLEN_DEF   = 32;
    localparam int GPR_AW_DEF = 5;

    typedef struct packed {
        logic                  err;
        logic                  wen;
        logic [GPR_AW_DEF-1:0] wa;
        logic [XLEN_DEF-1:0]   wd;
    } upimm_payload_t;

    function automatic logic is_upimm(input logic [6:0] opcode);
        return (opcode == OPCODE_LUI) || (opcode == OPCODE_AUIPC);
    endfunction

endpackage

// File: rtl/exu_pipe_slice.sv
// exu_pipe_slice: one valid/ready register stage carrying an opaque payload.
//   clk, rst           : clock, synchronous active-high reset
//   flush              : drop the held op (valid clears next cycle)
//   in_valid, in_data  : upstream op; taken whenever the stage advances
//   out_ready          : downstream can take the held op this cycle
//   out_valid, out_data: held op, straight from the registers
// The upstream ready is not an output: the parent derives the whole ready
// chain from the stage valids so no combinational path runs through here.
module exu_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         advance;

    assign advance = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (advance) begin
            valid_d = in_valid;
            // Data moves only with a real op, so bubbles never disturb it.
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/exu_upimm_pipe.sv
// exu_upimm_pipe: elastic, DEPTH-stage pipelined handler for LUI and AUIPC.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : issue handshake
//   in_inst, in_pc               : instruction word and its PC
//   flush                        : kill every in-flight op, refuse issue
//   wb_valid/wb_ready            : write-back handshake
//   wb_wen, wb_wa, wb_wd, wb_err : write-back payload (last-stage registers)
//   busy                         : any stage holds an op
//   retire_cnt                   : error-free ops written back (wraps)
module exu_upimm_pipe
    import exu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PC_W   = 32,
    parameter int GPR_AW = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_wen,
    output logic [GPR_AW-1:0] wb_wa,
    output logic [XLEN-1:0]   wb_wd,
    output logic              wb_err,
    output logic              busy,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef struct packed {
        logic              err;
        logic              wen;
        logic [GPR_AW-1:0] wa;
        logic [XLEN-1:0]   wd;
    } payload_t;

    localparam int PW = $bits(payload_t);

    logic [6:0]      opcode;
    logic [XLEN-1:0] u_imm;
    logic [XLEN-1:0] pc_ext;
    payload_t        in_pl;
    payload_t        out_pl;

    assign opcode = in_inst[6:0];
    // A sized cast of a signed value sign-extends, giving the XLEN=64 upper bits.
    assign u_imm  = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign pc_ext = XLEN'(in_pc);

    always_comb begin
        in_pl     = '0;
        in_pl.wa  = GPR_AW'(in_inst[11:7]);
        in_pl.err = !is_upimm(opcode);
        if (opcode == OPCODE_LUI) begin
            in_pl.wd = u_imm;
        end else if (opcode == OPCODE_AUIPC) begin
            in_pl.wd = pc_ext + u_imm;
        end
        in_pl.wen = !in_pl.err && (in_pl.wa != '0);
    end

    logic [DEPTH-1:0] v_s;
    logic [PW-1:0]    d_s [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic          up_valid;
        logic [PW-1:0] up_data;
        logic          dn_ready;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_pl;
        end else begin : g_body
            assign up_valid = v_s[i-1];
            assign up_data  = d_s[i-1];
        end

        // Stage i+1 accepts iff write-back is ready or some stage from i+1 to
        // the end has a hole; computing it from valids avoids a long
        // ready-through-ready combinational chain.
        if (i == DEPTH-1) begin : g_tail
            assign dn_ready = wb_ready;
        end else begin : g_mid
            assign dn_ready = wb_ready || !(&v_s[DEPTH-1:i+1]);
        end

        exu_pipe_slice #(.W(PW)) u_slice (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (up_valid),
            .in_data   (up_data),
            .out_ready (dn_ready),
            .out_valid (v_s[i]),
            .out_data  (d_s[i])
        );
    end

    assign out_pl   = payload_t'(d_s[DEPTH-1]);
    assign in_ready = (wb_ready || !(&v_s)) && !flush;
    assign wb_valid = v_s[DEPTH-1] && !flush;
    assign wb_wen   = out_pl.wen;
    assign wb_wa    = out_pl.wa;
    assign wb_wd    = out_pl.wd;
    assign wb_err   = out_pl.err;
    assign busy     = |v_s;

    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (wb_valid && wb_ready && !out_pl.err) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_exu_upimm_pipe.sv
module tb_exu_upimm_pipe;

    localparam int DEPTH   = 2;
    localparam int DEPTH64 = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst, in_valid, in_ready, flush, wb_valid, wb_ready;
    logic        wb_wen, wb_err, busy;
    logic [31:0] in_inst, in_pc, wb_wd, retire_cnt;
    logic [4:0]  wb_wa;

    // 64-bit instance
    logic        rst64, in_valid64, in_ready64, flush64, wb_valid64, wb_ready64;
    logic        wb_wen64, wb_err64, busy64;
    logic [31:0] in_inst64, in_pc64, retire_cnt64;
    logic [63:0] wb_wd64;
    logic [4:0]  wb_wa64;

    exu_upimm_pipe #(.XLEN(32), .PC_W(32), .GPR_AW(5), .DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen),
        .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_err(wb_err),
        .busy(busy), .retire_cnt(retire_cnt)
    );

    exu_upimm_pipe #(.XLEN(64), .PC_W(32), .GPR_AW(5), .DEPTH(DEPTH64), .CNT_W(32)) dut64 (
        .clk(clk), .rst(rst64), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_inst(in_inst64), .in_pc(in_pc64), .flush(flush64),
        .wb_valid(wb_valid64), .wb_ready(wb_ready64), .wb_wen(wb_wen64),
        .wb_wa(wb_wa64), .wb_wd(wb_wd64), .wb_err(wb_err64),
        .busy(busy64), .retire_cnt(retire_cnt64)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural result of one U-type op.
    typedef struct {
        logic        err;
        logic        wen;
        logic [4:0]  wa;
        logic [63:0] wd;
    } exp_t;

    function automatic exp_t ref_op(input logic [31:0] inst, input logic [31:0] pc, input int xlen);
        exp_t   e;
        longint imm;
        longint mask;
        imm    = longint'($signed(inst[31:12])) * 64'sd4096;
        mask   = (xlen == 64) ? -64'sd1 : 64'sh0000_0000_FFFF_FFFF;
        e.wa   = inst[11:7];
        e.err  = 1'b0;
        e.wd   = 64'd0;
        if (inst[6:0] == 7'h37)
            e.wd = imm & mask;
        else if (inst[6:0] == 7'h17)
            e.wd = (longint'({32'd0, pc}) + imm) & mask;
        else
            e.err = 1'b1;
        e.wen = !e.err && (e.wa != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] mk(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic logic [31:0] rand_inst();
        int         sel;
        logic [6:0] opc;
        logic [4:0] rd;
        sel = $urandom_range(0, 9);
        if (sel < 4)      opc = 7'h37;
        else if (sel < 8) opc = 7'h17;
        else begin
            opc = 7'($urandom);
            if (opc == 7'h37 || opc == 7'h17) opc = 7'b0110011;
        end
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        return mk(20'($urandom), rd, opc);
    endfunction

    // Scoreboard on the 32-bit instance: sampled at negedge, where the
    // handshakes about to complete at the next rising edge are stable.
    exp_t        q[$];
    logic [31:0] m_cnt;
    logic        hold;
    logic [31:0] p_wd;
    logic [4:0]  p_wa;
    logic        p_wen, p_err;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            m_cnt = 32'd0;
            hold  = 1'b0;
        end else begin
            chk("busy", busy, q.size() != 0);
            chk("in_ready", in_ready, !flush && (q.size() < DEPTH || wb_ready));
            chk("retire_cnt", retire_cnt, m_cnt);
            if (hold && !flush) begin
                chk("hold_valid", wb_valid, 1'b1);
                chk("hold_wd", wb_wd, p_wd);
                chk("hold_wa", wb_wa, p_wa);
                chk("hold_wen", wb_wen, p_wen);
                chk("hold_err", wb_err, p_err);
            end
            if (flush) begin
                chk("flush_no_wb", wb_valid, 1'b0);
                q.delete();
                hold = 1'b0;
            end else begin
                if (wb_valid && wb_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_wb", 1'b1, 1'b0);
                    end else begin
                        e = q.pop_front();
                        chk("wb_wa", wb_wa, e.wa);
                        chk("wb_wd", wb_wd, e.wd);
                        chk("wb_wen", wb_wen, e.wen);
                        chk("wb_err", wb_err, e.err);
                        if (!e.err) m_cnt = m_cnt + 32'd1;
                    end
                end
                if (in_valid && in_ready) q.push_back(ref_op(in_inst, in_pc, 32));
                hold  = wb_valid && !wb_ready;
                p_wd  = wb_wd;
                p_wa  = wb_wa;
                p_wen = wb_wen;
                p_err = wb_err;
            end
        end
    end

    // Drive one cycle of the 32-bit instance; returns whether the op was taken.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic wbr, input logic fl, output logic took);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
        wb_ready = wbr;
        flush    = fl;
        #1;
        took = v && in_ready;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic t;
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, t);
    endtask

    task automatic drain();
        logic t;
        for (int k = 0; k < 40 && (q.size() != 0 || busy); k++)
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, t);
        chk("drain_empty", q.size(), 0);
        chk("drain_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        t;
        logic [31:0] ops [4];
        int          idx, acc, lat;
        logic [31:0] c0;

        rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
        flush = 1'b0; wb_ready = 1'b1;
        rst64 = 1'b1; in_valid64 = 1'b0; in_inst64 = 32'd0; in_pc64 = 32'd0;
        flush64 = 1'b0; wb_ready64 = 1'b1;
        @(posedge clk); #1;
        idle(2);
        rst = 1'b0; rst64 = 1'b0;
        #1;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wen", wb_wen, 1'b0);
        chk("rst_err", wb_err, 1'b0);
        chk("rst_wa", wb_wa, 5'd0);
        chk("rst_wd", wb_wd, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        chk("rst_in_ready", in_ready, 1'b1);

        // LUI x5 latency and result
        step(1'b1, mk(20'h12345, 5'd5, 7'h37), 32'd0, 1'b1, 1'b0, t);
        chk("t1_wbv_early", wb_valid, 1'b0);
        chk("t1_busy", busy, 1'b1);
        idle(1);
        chk("t1_wbv", wb_valid, 1'b1);
        chk("t1_wa", wb_wa, 5'd5);
        chk("t1_wd", wb_wd, 32'h12345000);
        chk("t1_wen", wb_wen, 1'b1);
        idle(1);
        chk("t1_cnt", retire_cnt, 32'd1);
        chk("t1_wbv_after", wb_valid, 1'b0);

        // AUIPC wrap then back-to-back at full rate
        for (int k = 0; k < 10; k++) begin
            if (k >= DEPTH) chk("t2_rate", wb_valid, 1'b1);
            if (k == DEPTH) chk("t2_wrap", wb_wd, 32'd0);
            if (k == 0) step(1'b1, mk(20'hFFFFF, 5'd1, 7'h17), 32'h1000, 1'b1, 1'b0, t);
            else        step(1'b1, rand_inst(), $urandom, 1'b1, 1'b0, t);
            chk("t2_ready", t, 1'b1);
        end
        drain();

        // Back-pressure: 5 stalled cycles, 4 ops offered
        for (int k = 0; k < 4; k++) ops[k] = rand_inst();
        idx = 0; acc = 0;
        for (int c = 0; c < 5; c++) begin
            step(idx < 4, ops[idx < 4 ? idx : 0], 32'h8000 + 32'(idx), 1'b0, 1'b0, t);
            if (c >= DEPTH) chk("t3_ready_low", t, 1'b0);
            if (t) begin idx++; acc++; end
        end
        chk("t3_accepts", acc, DEPTH);
        for (int c = 0; c < 20 && idx < 4; c++) begin
            step(1'b1, ops[idx], 32'h8000 + 32'(idx), 1'b1, 1'b0, t);
            if (t) idx++;
        end
        chk("t3_all_issued", idx, 4);
        drain();

        // LUI x0 retires with no write; illegal opcode reports error
        c0 = retire_cnt;
        step(1'b1, mk(20'hABCDE, 5'd0, 7'h37), 32'd0, 1'b1, 1'b0, t);
        step(1'b1, mk(20'h11111, 5'd7, 7'b0110011), 32'd0, 1'b1, 1'b0, t);
        drain();
        chk("t4_cnt", retire_cnt, c0 + 32'd1);

        // Flush with two ops in flight and a new op offered
        step(1'b1, rand_inst(), $urandom, 1'b0, 1'b0, t);
        step(1'b1, rand_inst(), $urandom, 1'b0, 1'b0, t);
        chk("t5_inflight", busy, 1'b1);
        c0 = retire_cnt;
        step(1'b1, mk(20'h00042, 5'd9, 7'h37), 32'd0, 1'b1, 1'b1, t);
        chk("t5_flush_took", t, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_wbv", wb_valid, 1'b0);
        chk("t5_cnt", retire_cnt, c0);
        idle(3);
        chk("t5_dropped", busy, 1'b0);
        chk("t5_cnt_after", retire_cnt, c0);

        // Randomized traffic with stalls and occasional flush
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) < 7, rand_inst(), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, t);
        end
        drain();

        // 64-bit instance: sign-extended LUI, latency, then reset mid-stream
        in_valid64 = 1'b1;
        in_inst64  = mk(20'h80000, 5'd3, 7'h37);
        in_pc64    = 32'h0;
        #1;
        chk("x64_ready", in_ready64, 1'b1);
        idle(1);
        in_valid64 = 1'b0;
        lat = 1;
        while (!wb_valid64 && lat < 10) begin idle(1); lat++; end
        chk("x64_latency", lat, DEPTH64);
        chk("x64_wd", wb_wd64, 64'hFFFFFFFF80000000);
        chk("x64_wa", wb_wa64, 5'd3);
        chk("x64_wen", wb_wen64, 1'b1);
        idle(1);
        chk("x64_cnt", retire_cnt64, 32'd1);
        in_valid64 = 1'b1;
        in_inst64  = mk(20'h7FFFF, 5'd4, 7'h17);
        in_pc64    = 32'hFFFF_F000;
        idle(2);
        in_valid64 = 1'b0;
        chk("x64_busy_pre", busy64, 1'b1);
        rst64 = 1'b1;
        idle(1);
        rst64 = 1'b0;
        #1;
        chk("x64_rst_wbv", wb_valid64, 1'b0);
        chk("x64_rst_busy", busy64, 1'b0);
        chk("x64_rst_wen", wb_wen64, 1'b0);
        chk("x64_rst_err", wb_err64, 1'b0);
        chk("x64_rst_wa", wb_wa64, 5'd0);
        chk("x64_rst_wd", wb_wd64, 64'd0);
        chk("x64_rst_cnt", retire_cnt64, 32'd0);
        chk("x64_rst_ready", in_ready64, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
